// File: rtl/rgb_led_pkg.sv
// Shared types and constants for the soft-fade RGB LED driver.
package rgb_led_pkg;

  typedef enum logic [1:0] {
    CH_OFF,
    CH_RAMP_UP,
    CH_ON,
    CH_RAMP_DOWN
  } chan_state_e;

  localparam int NUM_CH = 3;
  localparam int CH_R   = 0;
  localparam int CH_G   = 1;
  localparam int CH_B   = 2;

  // The board's LED pins sink current, so a low pin means lit.
  localparam logic LED_LIT  = 1'b0;
  localparam logic LED_DARK = 1'b1;

  function automatic logic is_ramping(input chan_state_e s);
    return (s == CH_RAMP_UP) || (s == CH_RAMP_DOWN);
  endfunction

endpackage

// File: rtl/led_fade_chan.sv
// One colour channel: fade FSM, duty register, period-aligned duty shadow and PWM pin flop.
module led_fade_chan
  import rgb_led_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PWM_BITS-1:0] pwm_cnt_i,
  input  logic                pwm_wrap_i,
  input  logic                step_tick_i,
  input  logic                req_i,
  output logic                led_o,
  output logic [PWM_BITS-1:0] duty_o,
  output chan_state_e         state_o
);

  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

  chan_state_e         state_q, state_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [PWM_BITS-1:0] shadow_q, shadow_d;
  logic                led_q, led_d;
  logic                lit;

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    case (state_q)
      CH_OFF:       if (req_i)  state_d = CH_RAMP_UP;
      CH_RAMP_UP:   if (!req_i) state_d = CH_RAMP_DOWN;
      CH_ON:        if (!req_i) state_d = CH_RAMP_DOWN;
      CH_RAMP_DOWN: if (req_i)  state_d = CH_RAMP_UP;
      default:      state_d = CH_OFF;
    endcase
    // A step coinciding with a reversal already moves in the new direction.
    if (step_tick_i) begin
      if (state_d == CH_RAMP_UP && duty_q != DUTY_MAX) begin
        duty_d = duty_q + 1'b1;
      end else if (state_d == CH_RAMP_DOWN && duty_q != '0) begin
        duty_d = duty_q - 1'b1;
      end
    end
    if (state_d == CH_RAMP_UP && duty_d == DUTY_MAX) begin
      state_d = CH_ON;
    end else if (state_d == CH_RAMP_DOWN && duty_d == '0) begin
      state_d = CH_OFF;
    end
  end

  // Comparator sees a duty that only changes at period boundaries.
  always_comb begin
    shadow_d = pwm_wrap_i ? duty_q : shadow_q;
    lit      = (duty_q == DUTY_MAX) || (pwm_cnt_i < shadow_q);
    led_d    = lit ? LED_LIT : LED_DARK;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= CH_OFF;
      duty_q   <= '0;
      shadow_q <= '0;
      led_q    <= LED_DARK;
    end else begin
      state_q  <= state_d;
      duty_q   <= duty_d;
      shadow_q <= shadow_d;
      led_q    <= led_d;
    end
  end

  assign led_o   = led_q;
  assign duty_o  = duty_q;
  assign state_o = state_q;

endmodule

// File: rtl/rgb_led_fader.sv
// Soft-fade RGB LED driver: shared PWM counter and step prescaler feeding three fade channels.
module rgb_led_fader
  import rgb_led_pkg::*;
#(
  parameter int CLK_HZ      = 12_000_000,
  parameter int PWM_BITS    = 8,
  parameter int STEP_CYCLES = 23_529
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_r,
  input  logic                req_g,
  input  logic                req_b,
  output logic                LED_R,
  output logic                LED_G,
  output logic                LED_B,
  output logic [PWM_BITS-1:0] level_r,
  output logic [PWM_BITS-1:0] level_g,
  output logic [PWM_BITS-1:0] level_b,
  output logic [2:0]          busy
);

  // Degenerate settings collapse to a one-cycle step instead of an illegal prescaler.
  localparam int STEP_N  = (CLK_HZ > 0 && STEP_CYCLES > 0) ? STEP_CYCLES : 1;
  localparam int PRESC_W = (STEP_N > 1) ? $clog2(STEP_N) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(STEP_N - 1);

  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                pwm_wrap;
  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic                step_tick;

  always_comb begin
    pwm_wrap  = (pwm_cnt_q == '1);
    pwm_cnt_d = pwm_cnt_q + 1'b1;
    step_tick = (presc_q == PRESC_LAST);
    presc_d   = step_tick ? '0 : presc_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q <= '0;
      presc_q   <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      presc_q   <= presc_d;
    end
  end

  logic [NUM_CH-1:0]   req_v;
  logic [NUM_CH-1:0]   led_v;
  logic [PWM_BITS-1:0] duty_v  [NUM_CH];
  chan_state_e         state_v [NUM_CH];

  assign req_v[CH_R] = req_r;
  assign req_v[CH_G] = req_g;
  assign req_v[CH_B] = req_b;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
    led_fade_chan #(
      .PWM_BITS(PWM_BITS)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .pwm_cnt_i  (pwm_cnt_q),
      .pwm_wrap_i (pwm_wrap),
      .step_tick_i(step_tick),
      .req_i      (req_v[c]),
      .led_o      (led_v[c]),
      .duty_o     (duty_v[c]),
      .state_o    (state_v[c])
    );
    // state_v is a flop output, so busy settles one cycle after the change.
    assign busy[c] = is_ramping(state_v[c]);
  end

  assign LED_R   = led_v[CH_R];
  assign LED_G   = led_v[CH_G];
  assign LED_B   = led_v[CH_B];
  assign level_r = duty_v[CH_R];
  assign level_g = duty_v[CH_G];
  assign level_b = duty_v[CH_B];

endmodule

// File: tb/tb_rgb_led_fader.sv
// Bench for rgb_led_fader: cycle model feeding an expected queue, plus scenario tasks.
module tb_rgb_led_fader;

  localparam int PB   = 3;
  localparam int SC   = 4;
  localparam int MAXD = 7;
  localparam int S_OFF = 0, S_UP = 1, S_ON = 2, S_DN = 3;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic req_r = 1'b0, req_g = 1'b0, req_b = 1'b0;
  logic LED_R, LED_G, LED_B;
  logic [PB-1:0] level_r, level_g, level_b;
  logic [2:0] busy;

  logic s_req = 1'b0;
  logic s_led_r, s_led_g, s_led_b;
  logic [PB-1:0] s_lvl_r, s_lvl_g, s_lvl_b;
  logic [2:0] s_busy;

  int checks = 0;
  int errors = 0;
  int cyc;

  rgb_led_fader #(.CLK_HZ(12_000_000), .PWM_BITS(PB), .STEP_CYCLES(SC)) dut (
    .clk(clk), .rst_n(rst_n), .req_r(req_r), .req_g(req_g), .req_b(req_b),
    .LED_R(LED_R), .LED_G(LED_G), .LED_B(LED_B),
    .level_r(level_r), .level_g(level_g), .level_b(level_b), .busy(busy)
  );

  // Slow-stepping copy so a mid-ramp duty is held across several PWM periods.
  rgb_led_fader #(.CLK_HZ(12_000_000), .PWM_BITS(PB), .STEP_CYCLES(64)) dut_slow (
    .clk(clk), .rst_n(rst_n), .req_r(s_req), .req_g(1'b0), .req_b(1'b0),
    .LED_R(s_led_r), .LED_G(s_led_g), .LED_B(s_led_b),
    .level_r(s_lvl_r), .level_g(s_lvl_g), .level_b(s_lvl_b), .busy(s_busy)
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Reference model of the three channels
  logic [14:0] exp_q[$];
  int   m_pwm, m_presc;
  int   m_st[3], m_duty[3], m_shadow[3];
  int   n_st[3], n_duty[3], n_shadow[3];
  logic [2:0] n_led, n_busy, m_req;
  logic m_tick;
  logic [14:0] n_exp;

  assign m_req = {req_b, req_g, req_r};

  always_comb begin
    m_tick = (m_presc == SC - 1);
    n_led  = 3'b111;
    n_busy = 3'b000;
    for (int c = 0; c < 3; c++) begin
      n_st[c] = m_st[c];
      if (m_req[c] && (m_st[c] == S_OFF || m_st[c] == S_DN)) n_st[c] = S_UP;
      if (!m_req[c] && (m_st[c] == S_UP || m_st[c] == S_ON)) n_st[c] = S_DN;
      n_duty[c] = m_duty[c];
      if (m_tick && n_st[c] == S_UP && m_duty[c] < MAXD) n_duty[c] = m_duty[c] + 1;
      if (m_tick && n_st[c] == S_DN && m_duty[c] > 0)    n_duty[c] = m_duty[c] - 1;
      if (n_st[c] == S_UP && n_duty[c] == MAXD) n_st[c] = S_ON;
      if (n_st[c] == S_DN && n_duty[c] == 0)    n_st[c] = S_OFF;
      n_shadow[c] = (m_pwm == MAXD) ? m_duty[c] : m_shadow[c];
      n_led[c]    = !((m_duty[c] == MAXD) || (m_pwm < m_shadow[c]));
      n_busy[c]   = (n_st[c] == S_UP) || (n_st[c] == S_DN);
    end
    n_exp = {n_led, n_busy, 3'(n_duty[2]), 3'(n_duty[1]), 3'(n_duty[0])};
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pwm   <= 0;
      m_presc <= 0;
      for (int c = 0; c < 3; c++) begin
        m_st[c]     <= S_OFF;
        m_duty[c]   <= 0;
        m_shadow[c] <= 0;
      end
      exp_q.delete();
    end else begin
      m_pwm   <= (m_pwm + 1) % (MAXD + 1);
      m_presc <= m_tick ? 0 : m_presc + 1;
      for (int c = 0; c < 3; c++) begin
        m_st[c]     <= n_st[c];
        m_duty[c]   <= n_duty[c];
        m_shadow[c] <= n_shadow[c];
      end
      exp_q.push_back(n_exp);
    end
  end

  // Scoreboard: one expected word per clock, compared away from the active edge
  logic [14:0] sb_act, sb_exp;
  always @(negedge clk) begin
    sb_act = {LED_B, LED_G, LED_R, busy, level_b, level_g, level_r};
    if (!rst_n) begin
      checks++;
      if (sb_act !== 15'h7000) begin
        errors++;
        $display("FAIL sb_reset t=%0t got %h exp 7000", $time, sb_act);
      end
    end else if (exp_q.size() > 0) begin
      sb_exp = exp_q.pop_front();
      checks++;
      if (sb_act !== sb_exp) begin
        errors++;
        $display("FAIL sb_cycle t=%0t got %h exp %h", $time, sb_act, sb_exp);
      end
    end
  end

  // Driver / scenario tasks
  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      req_r = 1'($urandom_range(0, 1));
      req_g = 1'($urandom_range(0, 1));
      req_b = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if ({LED_B, LED_G, LED_R} !== 3'b111 || level_r !== 0 || level_g !== 0 ||
          level_b !== 0 || busy !== 3'b000) begin
        errors++;
        $display("FAIL reset_hold leds=%b lv=%0d/%0d/%0d busy=%b exp leds=111 lv=0 busy=0",
                 {LED_B, LED_G, LED_R}, level_r, level_g, level_b, busy);
      end
    end
    @(posedge clk); #1;
    req_r = 1'b0; req_g = 1'b0; req_b = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_ramp_up_g();
    int n, prev, lows;
    bit hit;
    @(posedge clk); #1; req_g = 1'b1;
    @(posedge clk); @(negedge clk); n = 1;
    checks++;
    if (busy[1] !== 1'b1) begin
      errors++; $display("FAIL up_busy got %b exp 1", busy[1]);
    end
    prev = int'(level_g);
    hit  = (level_g == 3'(MAXD));
    while (!hit && n < 60) begin
      @(negedge clk); n++;
      if (int'(level_g) != prev) begin
        checks++;
        if (level_g !== 3'(prev + 1)) begin
          errors++; $display("FAIL up_step got %0d exp %0d", level_g, prev + 1);
        end
        prev = int'(level_g);
      end
      if (level_g == 3'(MAXD)) hit = 1'b1;
    end
    checks++;
    if (!hit || n < 24 || n > 32) begin
      errors++; $display("FAIL up_time got %0d cycles (reached=%0d) exp 24..32", n, hit);
    end
    checks++;
    if (busy[1] !== 1'b0) begin
      errors++; $display("FAIL up_done_busy got %b exp 0", busy[1]);
    end
    repeat (2) @(negedge clk);
    lows = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (LED_G === 1'b0) lows++;
    end
    checks++;
    if (lows != 16) begin
      errors++; $display("FAIL up_pin_on got %0d low of 16 exp 16", lows);
    end
  endtask

  task automatic test_ramp_down_g();
    int n, prev, highs;
    bit hit;
    @(posedge clk); #1; req_g = 1'b0;
    n = 0; prev = int'(level_g); hit = 1'b0;
    while (!hit && n < 60) begin
      @(negedge clk); n++;
      if (int'(level_g) != prev) begin
        checks++;
        if (level_g !== 3'(prev - 1)) begin
          errors++; $display("FAIL down_step got %0d exp %0d", level_g, prev - 1);
        end
        prev = int'(level_g);
      end
      if (level_g == 3'd0) hit = 1'b1;
    end
    checks++;
    if (!hit || n < 24 || n > 32) begin
      errors++; $display("FAIL down_time got %0d cycles (reached=%0d) exp 24..32", n, hit);
    end
    checks++;
    if (busy[1] !== 1'b0) begin
      errors++; $display("FAIL down_off_busy got %b exp 0", busy[1]);
    end
    repeat (10) @(negedge clk);
    highs = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (LED_G === 1'b1) highs++;
    end
    checks++;
    if (highs != 16) begin
      errors++; $display("FAIL down_pin_off got %0d high of 16 exp 16", highs);
    end
  endtask

  task automatic test_reverse_r();
    int k, k_last, prev, changes;
    bit hit;
    @(posedge clk); #1; req_r = 1'b1;
    k = 0; hit = 1'b0;
    while (!hit && k < 40) begin
      @(negedge clk); k++;
      if (level_r == 3'd3) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      errors++; $display("FAIL rev_reach3 got %0d exp 3", level_r);
    end
    k_last = k; prev = 3; changes = 0;
    @(posedge clk); #1; req_r = 1'b0;
    while (prev != 0 && k < 80) begin
      @(negedge clk); k++;
      if (int'(level_r) != prev) begin
        checks++;
        if (level_r !== 3'(prev - 1)) begin
          errors++; $display("FAIL rev_step got %0d exp %0d", level_r, prev - 1);
        end
        checks++;
        if (k - k_last != SC) begin
          errors++; $display("FAIL rev_interval got %0d exp %0d", k - k_last, SC);
        end
        prev = int'(level_r); k_last = k; changes++;
      end
    end
    checks++;
    if (prev != 0 || changes != 3) begin
      errors++; $display("FAIL rev_done got level %0d after %0d steps exp 0 after 3", prev, changes);
    end
    @(negedge clk);
    checks++;
    if (busy[0] !== 1'b0) begin
      errors++; $display("FAIL rev_busy got %b exp 0", busy[0]);
    end
  endtask

  task automatic test_pwm_period();
    logic exp_low;
    @(posedge clk); #1; rst_n = 1'b0; s_req = 1'b1;
    @(posedge clk); #1; rst_n = 1'b1;
    while (cyc < 280) begin
      @(negedge clk);
      if (cyc >= 208) begin
        // Duty 3 shadowed until cycle 264, duty 4 afterwards; pin lags pwm by one flop.
        exp_low = (cyc < 264) ? (cyc % 8 >= 1 && cyc % 8 <= 3) : (cyc % 8 >= 1 && cyc % 8 <= 4);
        checks++;
        if (s_led_r !== ~exp_low) begin
          errors++; $display("FAIL pwm_pin cyc=%0d got %b exp %b", cyc, s_led_r, ~exp_low);
        end
      end
      if (cyc == 240 || cyc == 260) begin
        checks++;
        if (s_lvl_r !== ((cyc == 240) ? 3'd3 : 3'd4)) begin
          errors++; $display("FAIL pwm_level cyc=%0d got %0d", cyc, s_lvl_r);
        end
      end
    end
    s_req = 1'b0;
    checks++;
    if (s_busy[2:1] !== 2'b00 || s_lvl_g !== 0 || s_lvl_b !== 0 || s_led_g !== 1'b1 || s_led_b !== 1'b1) begin
      errors++; $display("FAIL pwm_idle_chans busy=%b lv=%0d/%0d pins=%b%b exp 00 0/0 11",
                         s_busy[2:1], s_lvl_g, s_lvl_b, s_led_g, s_led_b);
    end
  endtask

  task automatic test_reset_mid_ramp();
    int n;
    bit hit;
    @(posedge clk); #1; req_r = 1'b1; req_g = 1'b1; req_b = 1'b1;
    repeat (10) @(posedge clk);
    #1; rst_n = 1'b0;
    #1;
    checks++;
    if ({LED_B, LED_G, LED_R} !== 3'b111 || level_r !== 0 || level_g !== 0 ||
        level_b !== 0 || busy !== 3'b000) begin
      errors++;
      $display("FAIL midrst_async leds=%b lv=%0d/%0d/%0d busy=%b exp 111 0 0",
               {LED_B, LED_G, LED_R}, level_r, level_g, level_b, busy);
    end
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++;
    if (busy !== 3'b111 || level_r !== 0 || level_g !== 0 || level_b !== 0) begin
      errors++; $display("FAIL midrst_restart busy=%b lv=%0d/%0d/%0d exp 111 0/0/0",
                         busy, level_r, level_g, level_b);
    end
    n = 0; hit = 1'b0;
    while (!hit && n < 10) begin
      @(negedge clk); n++;
      if (level_r != 0) hit = 1'b1;
    end
    checks++;
    if (!hit || level_r !== 3'd1 || level_g !== 3'd1 || level_b !== 3'd1) begin
      errors++; $display("FAIL midrst_first_step lv=%0d/%0d/%0d exp 1/1/1", level_r, level_g, level_b);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      req_r = 1'($urandom_range(0, 1));
      req_g = 1'($urandom_range(0, 1));
      req_b = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 6)) @(posedge clk);
    end
    @(posedge clk); #1; req_r = 1'b0; req_g = 1'b0; req_b = 1'b0;
    n = 0;
    while (n < 40 && (busy !== 3'b000 || level_r !== 0 || level_g !== 0 || level_b !== 0)) begin
      @(negedge clk); n++;
    end
    checks++;
    if (busy !== 3'b000 || level_r !== 0 || level_g !== 0 || level_b !== 0) begin
      errors++; $display("FAIL b2b_settle busy=%b lv=%0d/%0d/%0d exp 000 0/0/0",
                         busy, level_r, level_g, level_b);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ramp_up_g();
    test_ramp_down_g();
    test_reverse_r();
    test_pwm_period();
    test_reset_mid_ramp();
    test_back_to_back();
    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rgb_led_fader.md
# rgb_led_fader

Soft-fade RGB LED driver for the iCESugar UP5K board. Consumes per-channel on/off level requests from upstream blink/sequencer logic and drives the active-low RGB LED pins with PWM, ramping brightness linearly up or down instead of hard-switching. Sits directly between blink-timing logic and the LED pins.

## Interface
- CLK_HZ, 12_000_000, board clock frequency (documentation only; not used in arithmetic)
- PWM_BITS, 8, PWM counter/duty width; PWM period = 2^PWM_BITS cycles
- STEP_CYCLES, 23_529, clock cycles per brightness step (≈0.5 s full ramp at 12 MHz, 8 bits)
- clk  in  1  board clock
- rst_n  in  1  asynchronous, active-low reset
- req_r / req_g / req_b  in  1 each  level request, 1 = channel should be lit
- LED_R / LED_G / LED_B  out  1 each  active-low LED pins, registered
- level_r / level_g / level_b  out  PWM_BITS each  current duty
- busy  out  3  per-channel ramp in progress, bit0=R, bit1=G, bit2=B

## Operation
- Reset: all duty = 0, all channels OFF, LED_* = 1, busy = 0, PWM counter = 0, step prescaler = 0.
- Free-running PWM counter pwm_cnt, 0 … 2^PWM_BITS−1, wraps to 0.
- Free-running step prescaler 0 … STEP_CYCLES−1; step_tick pulses one cycle when prescaler = STEP_CYCLES−1, then prescaler wraps to 0.
- Per-channel FSM, states OFF, RAMP_UP, ON, RAMP_DOWN:
  - OFF: duty = 0; req=1 → RAMP_UP.
  - RAMP_UP: on step_tick duty += 1; when duty reaches MAX = 2^PWM_BITS−1 → ON; req=0 → RAMP_DOWN immediately at current duty.
  - ON: duty = MAX; req=0 → RAMP_DOWN.
  - RAMP_DOWN: on step_tick duty −= 1; when duty reaches 0 → OFF; req=1 → RAMP_UP immediately at current duty.
- Duty saturates: never wraps above MAX or below 0.
- State change and step_tick in same cycle: transition takes effect; step applies in the new direction from that cycle onward (the step in that cycle follows the new state).
- busy bit = 1 in RAMP_UP/RAMP_DOWN, 0 in OFF/ON.
- Pin drive: lit = (duty = MAX) OR (pwm_cnt < duty_shadow); LED_x = ~lit. duty = 0 → pin constant 1; duty = MAX → pin constant 0.
- duty_shadow (used by comparator) reloads from duty only when pwm_cnt = 2^PWM_BITS−1, so a PWM period never glitches mid-cycle.

## Timing
- req change → FSM state change: 1 cycle (registered on next edge).
- duty change → pin effect: up to one PWM period (shadow reload) + 1 cycle output register.
- Full ramp 0→MAX: MAX step_ticks = MAX × STEP_CYCLES cycles (±STEP_CYCLES phase).
- level_* and busy are registered; valid the cycle after the change.
- rst_n assertion mid-ramp: all outputs return to reset values asynchronously; after deassert, channels resume from OFF.
- Requests are assumed synchronous to clk; no synchronizer inside.

## Structure
- Package rgb_led_pkg: channel state enum (OFF, RAMP_UP, ON, RAMP_DOWN), channel index constants R=0/G=1/B=2, active-low LED polarity constant.
- Shared in top: PWM counter, step prescaler.
- Sub-module led_fade_chan (one per colour, ×3): FSM, duty, shadow, comparator, output flop; inputs pwm_cnt, pwm_wrap, step_tick, req.

## Test plan
Use PWM_BITS=3, STEP_CYCLES=4 (MAX=7, full ramp 28 cycles).
- Reset held, toggle req_* → LED_*=1, level_*=0, busy=0 throughout.
- req_g 0→1 and hold → busy[1]=1, level_g 0→7 in 7 ticks (28 cycles ±4), then busy[1]=0, LED_G constant 0.
- From ON, req_g→0 → level_g 7→0 over 28 cycles, LED_G then constant 1, state OFF.
- req_r=1 until level_r=3, then req_r=0 → level_r reverses 3→2→1→0 on successive ticks; no overshoot, no wrap.
- level fixed at 3 → LED_R low exactly 3 of every 8 cycles, aligned to pwm_cnt 0..2; level change mid-period only affects next period.
- Assert rst_n=0 mid-ramp on all three channels → pins=1, level=0, busy=0 immediately; after release channel restarts ramp from 0 if req still 1.
